// File: rtl/round_scorer_if.sv
// round_scorer_if
//   Player-side bundle of the round scorer: control pulses and switch value
//   coming in, game status going out.
//
//   Inputs to the scorer (driven by the master side):
//     Start        single-cycle pulse, begins a game
//     Submit       single-cycle pulse, commits userNumber as the answer
//     Quit         single-cycle pulse, abandons the game
//     userNumber   8-bit switch value compared against the target
//   Outputs from the scorer (driven by the slave side):
//     targetNumber 8-bit target shown to the player
//     timeLeft     6-bit seconds remaining in the round
//     roundNum     4-bit current round, 1-based
//     score        8-bit running game score
//     bestScore    8-bit best completed-game score
//     busy         high while a round is being loaded or played
//     gameDone     high after the last round of a game
//     hit, miss    one-cycle result pulses
interface round_scorer_if;
  logic       Start;
  logic       Submit;
  logic       Quit;
  logic [7:0] userNumber;
  logic [7:0] targetNumber;
  logic [5:0] timeLeft;
  logic [3:0] roundNum;
  logic [7:0] score;
  logic [7:0] bestScore;
  logic       busy;
  logic       gameDone;
  logic       hit;
  logic       miss;

  modport master (
    output Start, Submit, Quit, userNumber,
    input  targetNumber, timeLeft, roundNum, score, bestScore,
           busy, gameDone, hit, miss
  );

  modport slave (
    input  Start, Submit, Quit, userNumber,
    output targetNumber, timeLeft, roundNum, score, bestScore,
           busy, gameDone, hit, miss
  );
endinterface

// File: rtl/round_scorer.sv
// round_scorer
//   Timed number-matching game. Each game is ROUNDS rounds long; every round
//   loads a pseudo-random target from a free-running LFSR and gives the
//   player ROUND_SECS seconds to submit a matching switch value. A match adds
//   the seconds still left to the score; a mismatch or a timeout scores
//   nothing. The best finished-game score is kept until reset.
//
//   Parameters:
//     TICK_DIV    Clk cycles per one-second tick (>= 2)
//     ROUND_SECS  seconds per round (1..63)
//     ROUNDS      rounds per game (1..15)
//   Ports:
//     Clk         system clock, rising edge
//     Reset       synchronous, active-high reset
//     game        round_scorer_if.slave bundle (controls in, status out)
//
//   Build option:
//     ROUND_SCORER_STREAK_EN  when defined, consecutive hits earn a bonus
//                             equal to the current streak length (0..15).
module round_scorer #(
  parameter int TICK_DIV   = 100000000,
  parameter int ROUND_SECS = 30,
  parameter int ROUNDS     = 5
) (
  input logic           Clk,
  input logic           Reset,
  round_scorer_if.slave game
);

  localparam int                TICK_W     = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [5:0]        SECS_INIT  = 6'(ROUND_SECS);
  localparam logic [3:0]        LAST_ROUND = 4'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t            state_q;
  logic [7:0]        lfsr_q;
  logic [7:0]        target_q;
  logic [5:0]        time_q;
  logic [3:0]        round_q;
  logic [7:0]        score_q;
  logic [7:0]        best_q;
  logic [TICK_W-1:0] tick_q;
  logic              busy_q;
  logic              done_q;
  logic              hit_q;
  logic              miss_q;

  logic [3:0]        bonus;
  logic              terminal;
  logic              is_match;
  logic              timeout;
  logic              round_end;
  logic              last_round;
  logic [9:0]        raw_sum;
  logic [7:0]        hit_score;
  logic [7:0]        final_score;

`ifdef ROUND_SCORER_STREAK_EN
  logic [3:0]        streak_q;
  assign bonus = streak_q;
`else
  assign bonus = 4'd0;
`endif

  assign terminal   = (tick_q == TICK_LAST);
  assign is_match   = (game.userNumber == target_q);
  // A submit in the same cycle as the final tick beats the timeout.
  assign timeout    = terminal && (time_q == 6'd1) && !game.Submit;
  assign round_end  = game.Submit || timeout;
  assign last_round = (round_q >= LAST_ROUND);

  // Wide enough that score + seconds + streak never wraps before saturating.
  assign raw_sum     = {2'b00, score_q} + {4'b0000, time_q} + {6'b000000, bonus};
  assign hit_score   = (raw_sum > 10'd255) ? 8'hFF : raw_sum[7:0];
  // Score the game ends with, so bestScore can see a hit on the last round.
  assign final_score = (game.Submit && is_match) ? hit_score : score_q;

  // Free-running target source; shift-left Fibonacci form with taps 8,6,5,4.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Game sequencer. Status outputs are registered alongside every state
  // change so busy/gameDone always agree with the state held in state_q.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      target_q <= 8'h00;
      time_q   <= 6'd0;
      round_q  <= 4'd0;
      score_q  <= 8'h00;
      best_q   <= 8'h00;
      tick_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
`ifdef ROUND_SCORER_STREAK_EN
      streak_q <= 4'd0;
`endif
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      if (game.Quit && (state_q != IDLE)) begin
        // Abandoned game keeps its score on display but never counts as best.
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (game.Start) begin
              state_q  <= LOAD;
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              score_q  <= 8'h00;
              round_q  <= 4'd0;
`ifdef ROUND_SCORER_STREAK_EN
              streak_q <= 4'd0;
`endif
            end
          end
          LOAD: begin
            target_q <= lfsr_q;
            time_q   <= SECS_INIT;
            round_q  <= round_q + 4'd1;
            tick_q   <= '0;
            state_q  <= RUN;
          end
          RUN: begin
            if (terminal) begin
              tick_q <= '0;
              time_q <= time_q - 6'd1;
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
            if (round_end) begin
              if (game.Submit && is_match) begin
                hit_q   <= 1'b1;
                score_q <= hit_score;
`ifdef ROUND_SCORER_STREAK_EN
                if (streak_q != 4'hF) begin
                  streak_q <= streak_q + 4'd1;
                end
`endif
              end else begin
                miss_q <= 1'b1;
`ifdef ROUND_SCORER_STREAK_EN
                streak_q <= 4'd0;
`endif
              end
              if (last_round) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                best_q  <= (final_score > best_q) ? final_score : best_q;
              end else begin
                state_q <= LOAD;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign game.targetNumber = target_q;
  assign game.timeLeft     = time_q;
  assign game.roundNum     = round_q;
  assign game.score        = score_q;
  assign game.bestScore    = best_q;
  assign game.busy         = busy_q;
  assign game.gameDone     = done_q;
  assign game.hit          = hit_q;
  assign game.miss         = miss_q;

endmodule

// File: tb/tb_round_scorer.sv
// tb_round_scorer
//   Self-checking bench for round_scorer with TICK_DIV=4, ROUND_SECS=10,
//   ROUNDS=3. Drives the player interface, plays scripted and random games
//   and compares the status outputs against a game-level scoring model.
//   Honours ROUND_SCORER_STREAK_EN the same way the design does.
module tb_round_scorer;

  localparam int TICK_DIV     = 4;
  localparam int ROUND_SECS   = 10;
  localparam int ROUNDS       = 3;
  localparam int ROUND_CYCLES = TICK_DIV * ROUND_SECS;

  typedef struct {
    int waitCycles;
    bit match;
    int expScore;
    bit expHit;
    bit expMiss;
  } roundVec_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  round_scorer_if game();

  round_scorer #(
    .TICK_DIV  (TICK_DIV),
    .ROUND_SECS(ROUND_SECS),
    .ROUNDS    (ROUNDS)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .game (game)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 Clk = ~Clk;

  // Target source model: the x^8+x^6+x^5+x^4+1 sequence from seed 1.
  // mPrev holds the value the design had during the cycle that just ended.
  logic [7:0] mLfsr = 8'h01;
  logic [7:0] mPrev = 8'h01;
  always @(posedge Clk) begin
    mPrev = mLfsr;
    if (Reset) mLfsr = 8'h01;
    else       mLfsr = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
  end

  // Game-level scoring model state.
  int mScore  = 0;
  int mStreak = 0;
  int mBest   = 0;
  int mRound  = 0;
  bit mHit;
  bit mMiss;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit start, input bit submit, input bit quit,
                               input logic [7:0] user);
    game.Start      = start;
    game.Submit     = submit;
    game.Quit       = quit;
    game.userNumber = user;
    @(posedge Clk);
    #1;
    game.Start  = 1'b0;
    game.Submit = 1'b0;
    game.Quit   = 1'b0;
  endtask

  // Scoring rules: a submit w cycles into a round sees ROUND_SECS - w/TICK_DIV
  // seconds left; the round times out at cycle ROUND_CYCLES-1 if nothing came.
  task automatic modelRound(input int w, input bit match);
    int secs;
    int add;
    mRound++;
    mHit  = 1'b0;
    mMiss = 1'b0;
    if (w < ROUND_CYCLES && match) begin
      secs = ROUND_SECS - w / TICK_DIV;
`ifdef ROUND_SCORER_STREAK_EN
      add = secs + mStreak;
`else
      add = secs;
`endif
      mScore  = (mScore + add > 255) ? 255 : mScore + add;
      mStreak = (mStreak < 15) ? mStreak + 1 : 15;
      mHit    = 1'b1;
    end else begin
      mStreak = 0;
      mMiss   = 1'b1;
    end
    if (mRound == ROUNDS && mScore > mBest) mBest = mScore;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_target"},   game.targetNumber, 0);
    checkOutput({tag, "_timeLeft"}, game.timeLeft, 0);
    checkOutput({tag, "_roundNum"}, game.roundNum, 0);
    checkOutput({tag, "_score"},    game.score, 0);
    checkOutput({tag, "_best"},     game.bestScore, 0);
    checkOutput({tag, "_busy"},     game.busy, 0);
    checkOutput({tag, "_gameDone"}, game.gameDone, 0);
    checkOutput({tag, "_hit"},      game.hit, 0);
    checkOutput({tag, "_miss"},     game.miss, 0);
  endtask

  // Start pulse -> LOAD cycle -> first RUN cycle.
  task automatic startGame();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("load_busy", game.busy, 1);
    checkOutput("load_gameDone", game.gameDone, 0);
    checkOutput("load_score", game.score, 0);
    checkOutput("load_roundNum", game.roundNum, 0);
    checkOutput("load_best", game.bestScore, mBest);
    mScore  = 0;
    mStreak = 0;
    mRound  = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Entered on the first RUN cycle of a round; leaves on the first RUN cycle
  // of the next round, or in DONE after the last round.
  task automatic playRound(input int w, input bit match, output bit gotHit, output bit gotMiss);
    logic [7:0] tgt;
    tgt = mPrev;
    modelRound(w, match);
    checkOutput("run_timeLeft", game.timeLeft, ROUND_SECS);
    checkOutput("run_roundNum", game.roundNum, mRound);
    checkOutput("run_target", game.targetNumber, tgt);
    checkOutput("run_busy", game.busy, 1);
    if (w >= ROUND_CYCLES) begin
      repeat (ROUND_CYCLES) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("timeout_timeLeft", game.timeLeft, 0);
    end else begin
      repeat (w) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("submit_timeLeft", game.timeLeft, ROUND_SECS - w / TICK_DIV);
      applyStimulus(1'b0, 1'b1, 1'b0, match ? tgt : ~tgt);
    end
    gotHit  = game.hit;
    gotMiss = game.miss;
    checkOutput("round_hit", game.hit, mHit);
    checkOutput("round_miss", game.miss, mMiss);
    checkOutput("round_score", game.score, mScore);
    if (mRound == ROUNDS) begin
      checkOutput("done_gameDone", game.gameDone, 1);
      checkOutput("done_busy", game.busy, 0);
      checkOutput("done_best", game.bestScore, mBest);
    end else begin
      checkOutput("next_busy", game.busy, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    end
  endtask

  roundVec_t  vectors [6];
  bit         gotHit;
  bit         gotMiss;
  logic [7:0] tgt2;
  int         game2Best;
  int         streakScore;

  initial begin
    game.Start      = 1'b0;
    game.Submit     = 1'b0;
    game.Quit       = 1'b0;
    game.userNumber = 8'h00;

    // Two scripted games: hit/timeout/mismatch, then coincident-tick cases.
    vectors[0] = '{8,  1'b1, 8,  1'b1, 1'b0};
    vectors[1] = '{45, 1'b1, 8,  1'b0, 1'b1};
    vectors[2] = '{3,  1'b0, 8,  1'b0, 1'b1};
    vectors[3] = '{23, 1'b1, 5,  1'b1, 1'b0};
`ifdef ROUND_SCORER_STREAK_EN
    vectors[4] = '{0,  1'b1, 16, 1'b1, 1'b0};
    vectors[5] = '{39, 1'b1, 19, 1'b1, 1'b0};
    game2Best   = 19;
    streakScore = 33;
`else
    vectors[4] = '{0,  1'b1, 15, 1'b1, 1'b0};
    vectors[5] = '{39, 1'b1, 16, 1'b1, 1'b0};
    game2Best   = 16;
    streakScore = 30;
`endif

    // Reset, including a Start that must be overridden.
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkAllZero("reset");
    Reset = 1'b0;

    for (int g = 0; g < 2; g++) begin
      startGame();
      for (int r = 0; r < ROUNDS; r++) begin
        playRound(vectors[g*3+r].waitCycles, vectors[g*3+r].match, gotHit, gotMiss);
        checkOutput($sformatf("tbl%0d_hit", g*3+r), gotHit, vectors[g*3+r].expHit);
        checkOutput($sformatf("tbl%0d_miss", g*3+r), gotMiss, vectors[g*3+r].expMiss);
        checkOutput($sformatf("tbl%0d_score", g*3+r), game.score, vectors[g*3+r].expScore);
      end
      checkOutput($sformatf("tbl_game%0d_best", g), game.bestScore, (g == 0) ? 8 : game2Best);
    end

    // Quit mid-round: Start ignored while busy, Quit beats a matching Submit.
    startGame();
    playRound(8, 1'b1, gotHit, gotMiss);
    tgt2 = mPrev;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("ignore_start_roundNum", game.roundNum, 2);
    checkOutput("ignore_start_timeLeft", game.timeLeft, ROUND_SECS);
    checkOutput("ignore_start_busy", game.busy, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, tgt2);
    checkOutput("quit_busy", game.busy, 0);
    checkOutput("quit_gameDone", game.gameDone, 0);
    checkOutput("quit_hit", game.hit, 0);
    checkOutput("quit_score", game.score, 8);
    checkOutput("quit_best", game.bestScore, game2Best);
    applyStimulus(1'b0, 1'b1, 1'b0, tgt2);
    checkOutput("idle_submit_hit", game.hit, 0);
    checkOutput("idle_submit_miss", game.miss, 0);
    checkOutput("idle_submit_score", game.score, 8);

    // Reset in the middle of a round clears everything, best included.
    startGame();
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    Reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkAllZero("midreset");
    Reset = 1'b0;
    mBest   = 0;
    mScore  = 0;
    mStreak = 0;

    // Three immediate hits: streak bonus shows up only with the option built in.
    startGame();
    for (int r = 0; r < ROUNDS; r++) playRound(0, 1'b1, gotHit, gotMiss);
    checkOutput("streak_score", game.score, streakScore);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("done_quit_gameDone", game.gameDone, 0);
    checkOutput("done_quit_score", game.score, streakScore);

    // Random games against the scoring model.
    for (int g = 0; g < 6; g++) begin
      startGame();
      for (int r = 0; r < ROUNDS; r++) begin
        playRound(int'($urandom_range(44, 0)), ($urandom_range(3, 0) != 0), gotHit, gotMiss);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_scorer.md
ROUND_SCORER -- requirements
Module: round_scorer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, Clk cycles per one-second tick (>=2).
REQ-002 SHALL have parameter ROUND_SECS, default 30, seconds per round (1..63).
REQ-003 SHALL have parameter ROUNDS, default 5, rounds per game (1..15).
REQ-004 SHALL have port Clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Start  input  1  single-cycle pulse; begins a game.
REQ-007 SHALL have port Submit  input  1  single-cycle pulse; user commits an answer.
REQ-008 SHALL have port Quit  input  1  single-cycle pulse; abandons the game.
REQ-009 SHALL have port userNumber  input  8  switch value to compare.
REQ-010 SHALL have port targetNumber  output  8  current target shown to player.
REQ-011 SHALL have port timeLeft  output  6  seconds remaining in the round.
REQ-012 SHALL have port roundNum  output  4  current round, 1-based; 0 when idle after reset.
REQ-013 SHALL have port score  output  8  running game score.
REQ-014 SHALL have port bestScore  output  8  best completed-game score.
REQ-015 SHALL have ports busy, gameDone, hit, miss  output  1 each  status; hit/miss are one-cycle pulses.

Function
REQ-016 SHALL run FSM states IDLE, LOAD, RUN, DONE; busy=1 in LOAD/RUN, gameDone=1 in DONE only.
REQ-017 SHALL keep an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) advancing every cycle, never zero.
REQ-018 IDLE or DONE + Start -> LOAD; score and roundNum cleared to 0 on that edge.
REQ-019 LOAD (one cycle): targetNumber<=LFSR, timeLeft<=ROUND_SECS, roundNum<=roundNum+1, tick counter<=0; -> RUN.
REQ-020 RUN: tick counter counts 0..TICK_DIV-1; on terminal count timeLeft decrements and counter wraps to 0.
REQ-021 RUN + Submit with userNumber==targetNumber: hit=1 next cycle, score<=min(255, score+timeLeft).
REQ-022 RUN + Submit with mismatch: miss=1 next cycle, score unchanged.
REQ-023 RUN with timeLeft==1 at terminal tick and no Submit: timeLeft->0, miss=1, round ends.
REQ-024 Submit and terminal tick in same cycle: Submit wins, scored with pre-decrement timeLeft.
REQ-025 Round end: -> LOAD if roundNum<ROUNDS, else -> DONE.
REQ-026 Entering DONE: bestScore<=max(bestScore, score).
REQ-027 Quit in LOAD/RUN/DONE: -> IDLE next cycle; score retained, bestScore not updated; Quit has priority over Submit and Start.
REQ-028 Start, Submit ignored outside states named above; Start ignored while busy.

Reset
REQ-029 Reset SHALL force IDLE, LFSR=8'h01, targetNumber=0, timeLeft=0, roundNum=0, score=0, bestScore=0, tick counter=0, busy=gameDone=hit=miss=0.
REQ-030 Reset SHALL override all inputs in the same cycle, including mid-round.

Configuration
REQ-031 Macro ROUND_SCORER_STREAK_EN defined: 4-bit streak counter (saturating at 15) increments on hit, clears on miss/Start/Reset; hit adds timeLeft+streak (pre-increment value), saturating at 255.
REQ-032 Macro undefined: no streak logic; hit adds timeLeft only.

Verification (TICK_DIV=4, ROUND_SECS=10, ROUNDS=3)
REQ-033 Reset, then Start -> next cycle LOAD, then RUN with timeLeft=10, roundNum=1, targetNumber nonzero, busy=1.
REQ-034 Round 1: userNumber=targetNumber, Submit after 8 cycles in RUN (timeLeft=8) -> hit pulse, score=8, roundNum=2.
REQ-035 Round 2: no Submit for 40 cycles -> timeLeft reaches 0, miss pulse, score stays 8, roundNum=3.
REQ-036 Round 3: mismatched Submit -> miss, DONE, gameDone=1, bestScore=8; new Start -> score=0, bestScore=8.
REQ-037 Submit coincident with terminal tick at timeLeft=5, matching -> score increases by 5, not 4.
REQ-038 Quit mid-round with score=8 -> IDLE, busy=0, bestScore unchanged; with STREAK_EN, three consecutive hits at timeLeft=10 -> score=10+11+12=33.
